// File: rtl/peak_scan_pkg.sv
// Shared types for the peak scan controller: FSM state encoding and the
// index-width helper used to size bin index ports and counters.
package peak_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of a bin index; a single-bin array still needs one bit.
  function automatic int IDX_W(input int samples);
    return (samples > 1) ? $clog2(samples) : 1;
  endfunction

endpackage

// File: rtl/bin_argmax_step.sv
// One-bin-per-cycle running argmax: holds the current candidate and applies
// the mask skip and the strictly-greater rule so ties keep the lowest index.
module bin_argmax_step
  import peak_scan_pkg::*;
#(
  parameter int IW    = 5,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_masked,
  input  logic [IW-1:0]    i_idx,
  input  logic [WIDTH-1:0] i_val,
  output logic [IW-1:0]    o_cand_idx,
  output logic [WIDTH-1:0] o_cand_val,
  output logic             o_cand_valid
);

  logic [IW-1:0]    r_cand_idx;
  logic [WIDTH-1:0] r_cand_val;
  logic             r_cand_valid;
  logic             w_take;

  // The first unmasked bin of a pass loads unconditionally.
  always_comb begin
    w_take = 1'b0;
    if (i_en && !i_masked) begin
      w_take = !r_cand_valid || (i_val > r_cand_val);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      r_cand_idx   <= '0;
      r_cand_val   <= '0;
      r_cand_valid <= 1'b0;
    end else if (i_clear) begin
      r_cand_idx   <= '0;
      r_cand_val   <= '0;
      r_cand_valid <= 1'b0;
    end else if (w_take) begin
      r_cand_idx   <= i_idx;
      r_cand_val   <= i_val;
      r_cand_valid <= 1'b1;
    end
  end

  assign o_cand_idx   = r_cand_idx;
  assign o_cand_val   = r_cand_val;
  assign o_cand_valid = r_cand_valid;

endmodule

// File: rtl/peak_scan_controller.sv
// Finds the PEAKS largest bins of a snapshotted spectrum by repeated masked
// argmax passes, one bin per cycle, reporting them in descending order.
module peak_scan_controller
  import peak_scan_pkg::*;
#(
  parameter  int SAMPLES = 32,
  parameter  int WIDTH   = 32,
  parameter  int PEAKS   = 3,
  localparam int IW      = IDX_W(SAMPLES)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [SAMPLES-1:0][WIDTH-1:0]  frequency_bins,
  output logic                           busy,
  output logic                           done,
  output logic [PEAKS-1:0][IW-1:0]       peak_index,
  output logic [PEAKS-1:0][WIDTH-1:0]    peak_value,
  output logic                           result_valid,
  output state_t                         debug_state
);

  localparam int CNT_W = $clog2(PEAKS + 1);

  // Handshake: start is a request accepted on a clock edge only when busy=0
  // and abort=0 (ready = !busy); frequency_bins is captured on that edge.
  // done pulses one cycle and result_valid then holds until the next accepted
  // start, an abort or reset.

  state_t                         r_state;
  state_t                         w_next_state;
  logic [SAMPLES-1:0][WIDTH-1:0]  r_snap;
  logic [SAMPLES-1:0]             r_mask;
  logic [IW-1:0]                  r_scan_idx;
  logic [CNT_W-1:0]               r_peak_cnt;
  logic [CNT_W-1:0]               w_peak_cnt_inc;
  logic [PEAKS-1:0][IW-1:0]       r_peak_index;
  logic [PEAKS-1:0][WIDTH-1:0]    r_peak_value;
  logic                           r_done;
  logic                           r_result_valid;

  logic                           w_accept;
  logic                           w_abort_hit;
  logic                           w_scan_en;
  logic                           w_cand_clear;
  logic                           w_commit;
  logic                           w_bin_masked;
  logic [WIDTH-1:0]               w_bin_val;
  logic [IW-1:0]                  w_cand_idx;
  logic [WIDTH-1:0]               w_cand_val;
  logic                           w_cand_valid;

  assign w_bin_masked   = r_mask[r_scan_idx];
  assign w_bin_val      = r_snap[r_scan_idx];
  assign w_peak_cnt_inc = r_peak_cnt + CNT_W'(1);

  bin_argmax_step #(
    .IW    (IW),
    .WIDTH (WIDTH)
  ) u_step (
    .clk          (clk),
    .i_reset_n    (reset),
    .i_clear      (w_cand_clear),
    .i_en         (w_scan_en),
    .i_masked     (w_bin_masked),
    .i_idx        (r_scan_idx),
    .i_val        (w_bin_val),
    .o_cand_idx   (w_cand_idx),
    .o_cand_val   (w_cand_val),
    .o_cand_valid (w_cand_valid)
  );

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_abort_hit  = 1'b0;
    w_scan_en    = 1'b0;
    w_cand_clear = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_accept     = 1'b1;
          w_cand_clear = 1'b1;
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          w_abort_hit  = 1'b1;
          w_cand_clear = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_scan_en = 1'b1;
          if (r_scan_idx == IW'(SAMPLES - 1)) begin
            w_next_state = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_cand_clear = 1'b1;
        if (abort) begin
          w_abort_hit  = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_commit     = 1'b1;
          w_next_state = (w_peak_cnt_inc < CNT_W'(PEAKS)) ? SCAN : DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (r_state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap <= '0;
    end else if (w_accept) begin
      r_snap <= frequency_bins;
    end
  end

  // The scan index wraps to 0 naturally after the last bin of each pass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scan_idx <= '0;
    end else if (w_accept || w_abort_hit) begin
      r_scan_idx <= '0;
    end else if (w_scan_en) begin
      r_scan_idx <= r_scan_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mask     <= '0;
      r_peak_cnt <= '0;
    end else if (w_accept || w_abort_hit) begin
      r_mask     <= '0;
      r_peak_cnt <= '0;
    end else if (w_commit && w_cand_valid) begin
      r_mask[w_cand_idx] <= 1'b1;
      r_peak_cnt         <= w_peak_cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_peak_index <= '0;
      r_peak_value <= '0;
    end else if (w_commit && w_cand_valid) begin
      for (int p = 0; p < PEAKS; p++) begin
        if (r_peak_cnt == CNT_W'(p)) begin
          r_peak_index[p] <= w_cand_idx;
          r_peak_value[p] <= w_cand_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result_valid <= 1'b0;
    end else if (w_accept || w_abort_hit) begin
      r_result_valid <= 1'b0;
    end else if (r_state == DONE) begin
      r_result_valid <= 1'b1;
    end
  end

  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign peak_index   = r_peak_index;
  assign peak_value   = r_peak_value;
  assign result_valid = r_result_valid;
  assign debug_state  = r_state;

endmodule

// File: tb/tb_peak_scan_controller.sv
// Self-checking bench for peak_scan_controller: an 8-bin/3-peak and a
// 4-bin/4-peak instance checked against a sort-based top-k reference model.
module tb_peak_scan_controller;
  import peak_scan_pkg::*;

  localparam int W   = 32;
  localparam int SA  = 8;
  localparam int PA  = 3;
  localparam int SB  = 4;
  localparam int PB  = 4;
  localparam int IWA = 3;
  localparam int IWB = 2;
  localparam int LAT_A = PA * (SA + 1) + 1;
  localparam int LAT_B = PB * (SB + 1) + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;

  logic                      start_a = 1'b0, abort_a = 1'b0;
  logic [SA-1:0][W-1:0]      bins_a = '0;
  logic                      busy_a, done_a, rv_a;
  logic [PA-1:0][IWA-1:0]    pidx_a;
  logic [PA-1:0][W-1:0]      pval_a;
  state_t                    st_a;

  logic                      start_b = 1'b0, abort_b = 1'b0;
  logic [SB-1:0][W-1:0]      bins_b = '0;
  logic                      busy_b, done_b, rv_b;
  logic [PB-1:0][IWB-1:0]    pidx_b;
  logic [PB-1:0][W-1:0]      pval_b;
  state_t                    st_b;

  peak_scan_controller #(.SAMPLES(SA), .WIDTH(W), .PEAKS(PA)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .frequency_bins(bins_a), .busy(busy_a), .done(done_a),
    .peak_index(pidx_a), .peak_value(pval_a), .result_valid(rv_a),
    .debug_state(st_a)
  );

  peak_scan_controller #(.SAMPLES(SB), .WIDTH(W), .PEAKS(PB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .frequency_bins(bins_b), .busy(busy_b), .done(done_b),
    .peak_index(pidx_b), .peak_value(pval_b), .result_valid(rv_b),
    .debug_state(st_b)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model: order bins by (value desc, index asc), keep first k
  function automatic void model_push(input logic [W-1:0] v[], input int k);
    int ord[$];
    int tmp;
    for (int i = 0; i < v.size(); i++) ord.push_back(i);
    for (int i = 1; i < ord.size(); i++) begin
      for (int j = i; j > 0; j--) begin
        if ((v[ord[j]] > v[ord[j-1]]) ||
            ((v[ord[j]] == v[ord[j-1]]) && (ord[j] < ord[j-1]))) begin
          tmp = ord[j]; ord[j] = ord[j-1]; ord[j-1] = tmp;
        end
      end
    end
    for (int p = 0; p < k; p++) begin
      exp_q.push_back(W'(ord[p]));
      exp_q.push_back(v[ord[p]]);
    end
  endfunction

  function automatic void model_push_a(input logic [SA-1:0][W-1:0] b);
    logic [W-1:0] v[];
    v = new[SA];
    for (int i = 0; i < SA; i++) v[i] = b[i];
    model_push(v, PA);
  endfunction

  function automatic void model_push_b(input logic [SB-1:0][W-1:0] b);
    logic [W-1:0] v[];
    v = new[SB];
    for (int i = 0; i < SB; i++) v[i] = b[i];
    model_push(v, PB);
  endfunction

  function automatic logic [SA-1:0][W-1:0] rand_bins_a(input int mode);
    logic [SA-1:0][W-1:0] b;
    for (int i = 0; i < SA; i++) b[i] = (mode == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
    return b;
  endfunction

  // driver tasks: called at a negedge, return at the negedge after the accept edge
  task automatic start_a_search(input logic [SA-1:0][W-1:0] b);
    bins_a = b; start_a = 1'b1;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic start_b_search(input logic [SB-1:0][W-1:0] b);
    bins_b = b; start_b = 1'b1;
    @(posedge clk); @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); @(negedge clk);
      if (done_a) begin lat = c; break; end
    end
  endtask

  task automatic wait_done_b(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); @(negedge clk);
      if (done_b) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (rv_a !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", rv_a); end
    checks++; if (pidx_a !== '0) begin errors++; $display("FAIL reset_idx got %h want 0", pidx_a); end
    checks++; if (pval_a !== '0) begin errors++; $display("FAIL reset_val got %h want 0", pval_a); end
    checks++; if (st_a !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", st_a); end
    checks++; if (busy_b !== 1'b0 || pidx_b !== '0) begin errors++; $display("FAIL reset_b got busy %b idx %h want 0", busy_b, pidx_b); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int d[SA] = '{5, 90, 12, 90, 3, 40, 7, 1};
    int ei[PA] = '{1, 3, 5};
    int ev[PA] = '{90, 90, 40};
    logic [SA-1:0][W-1:0] b;
    int lat;
    for (int i = 0; i < SA; i++) b[i] = W'(d[i]);
    start_a_search(b);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL dir_busy got %b want 1", busy_a); end
    wait_done_a(60, lat);
    checks++; if (lat != LAT_A) begin errors++; $display("FAIL dir_latency got %0d want %0d", lat, LAT_A); end
    checks++; if (rv_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL dir_flags got rv %b busy %b want 1 0", rv_a, busy_a); end
    for (int p = 0; p < PA; p++) begin
      checks++;
      if (int'(pidx_a[p]) != ei[p] || int'(pval_a[p]) != ev[p]) begin
        errors++; $display("FAIL dir_peak%0d got idx %0d val %0d want idx %0d val %0d", p, pidx_a[p], pval_a[p], ei[p], ev[p]);
      end
    end
    @(posedge clk); @(negedge clk);
    checks++; if (done_a !== 1'b0 || rv_a !== 1'b1) begin errors++; $display("FAIL dir_pulse got done %b rv %b want 0 1", done_a, rv_a); end
  endtask

  task automatic test_all_equal();
    logic [SA-1:0][W-1:0] b;
    int lat;
    for (int i = 0; i < SA; i++) b[i] = W'(7);
    start_a_search(b);
    wait_done_a(60, lat);
    checks++; if (lat != LAT_A) begin errors++; $display("FAIL eq_latency got %0d want %0d", lat, LAT_A); end
    for (int p = 0; p < PA; p++) begin
      checks++;
      if (int'(pidx_a[p]) != p || pval_a[p] !== W'(7)) begin
        errors++; $display("FAIL eq_peak%0d got idx %0d val %0d want idx %0d val 7", p, pidx_a[p], pval_a[p], p);
      end
    end
  endtask

  task automatic test_snapshot();
    logic [SA-1:0][W-1:0] b;
    logic [W-1:0] ei, ev;
    int lat, ndone;
    b = rand_bins_a(1);
    model_push_a(b);
    start_a_search(b);
    lat = -1; ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); @(negedge clk);
      if (done_a) begin ndone++; if (lat < 0) lat = c; end
      if (c == 2) bins_a = rand_bins_a(1);
      if (c == 5) start_a = 1'b1;
      if (c == 6) start_a = 1'b0;
      if (lat > 0 && c >= lat + 4) break;
    end
    checks++; if (lat != LAT_A) begin errors++; $display("FAIL snap_latency got %0d want %0d", lat, LAT_A); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL snap_done_count got %0d want 1", ndone); end
    for (int p = 0; p < PA; p++) begin
      ei = exp_q.pop_front(); ev = exp_q.pop_front();
      checks++;
      if (pidx_a[p] !== ei[IWA-1:0] || pval_a[p] !== ev) begin
        errors++; $display("FAIL snap_peak%0d got idx %0d val %0d want idx %0d val %0d", p, pidx_a[p], pval_a[p], ei, ev);
      end
    end
  endtask

  task automatic test_abort();
    logic [SA-1:0][W-1:0] b;
    logic [W-1:0] ei, ev;
    int lat, ndone;
    start_a_search(rand_bins_a(1));
    for (int c = 1; c <= 10; c++) begin @(posedge clk); @(negedge clk); end
    abort_a = 1'b1;
    @(posedge clk); @(negedge clk);
    abort_a = 1'b0;
    checks++; if (busy_a !== 1'b0 || st_a !== IDLE) begin errors++; $display("FAIL abort_busy got busy %b state %0d want 0 IDLE", busy_a, st_a); end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); @(negedge clk); if (done_a) ndone++; end
    checks++; if (ndone != 0 || rv_a !== 1'b0) begin errors++; $display("FAIL abort_nodone got done %0d rv %b want 0 0", ndone, rv_a); end
    b = rand_bins_a(0);
    model_push_a(b);
    start_a_search(b);
    wait_done_a(60, lat);
    checks++; if (lat != LAT_A) begin errors++; $display("FAIL abort_restart_latency got %0d want %0d", lat, LAT_A); end
    for (int p = 0; p < PA; p++) begin
      ei = exp_q.pop_front(); ev = exp_q.pop_front();
      checks++;
      if (pidx_a[p] !== ei[IWA-1:0] || pval_a[p] !== ev) begin
        errors++; $display("FAIL abort_restart_peak%0d got idx %0d val %0d want idx %0d val %0d", p, pidx_a[p], pval_a[p], ei, ev);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int ndone;
    start_a_search(rand_bins_a(1));
    repeat (4) begin @(posedge clk); @(negedge clk); end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || rv_a !== 1'b0 || pidx_a !== '0 || pval_a !== '0) begin
      errors++; $display("FAIL midreset_outputs got busy %b done %b rv %b idx %h val %h want all 0", busy_a, done_a, rv_a, pidx_a, pval_a);
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin @(posedge clk); @(negedge clk); if (done_a) ndone++; end
    checks++; if (ndone != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL midreset_nodone got done %0d busy %b want 0 0", ndone, busy_a); end
  endtask

  task automatic test_random();
    logic [SA-1:0][W-1:0] b;
    logic [W-1:0] ei, ev;
    int lat;
    for (int n = 0; n < 20; n++) begin
      b = rand_bins_a(n % 2);
      model_push_a(b);
      start_a_search(b);
      wait_done_a(60, lat);
      checks++; if (lat != LAT_A) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, lat, LAT_A); end
      for (int p = 0; p < PA; p++) begin
        ei = exp_q.pop_front(); ev = exp_q.pop_front();
        checks++;
        if (pidx_a[p] !== ei[IWA-1:0] || pval_a[p] !== ev) begin
          errors++; $display("FAIL rand%0d_peak%0d got idx %0d val %0d want idx %0d val %0d", n, p, pidx_a[p], pval_a[p], ei, ev);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [SA-1:0][W-1:0] b;
    logic [W-1:0] ei, ev;
    int lat;
    start_a_search(rand_bins_a(1));
    wait_done_a(60, lat);
    exp_q.delete();
    b = rand_bins_a(0);
    model_push_a(b);
    start_a_search(b);
    checks++; if (rv_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept got rv %b busy %b want 0 1", rv_a, busy_a); end
    wait_done_a(60, lat);
    checks++; if (lat != LAT_A) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT_A); end
    for (int p = 0; p < PA; p++) begin
      ei = exp_q.pop_front(); ev = exp_q.pop_front();
      checks++;
      if (pidx_a[p] !== ei[IWA-1:0] || pval_a[p] !== ev) begin
        errors++; $display("FAIL b2b_peak%0d got idx %0d val %0d want idx %0d val %0d", p, pidx_a[p], pval_a[p], ei, ev);
      end
    end
  endtask

  task automatic test_peaks_eq_samples();
    logic [SB-1:0][W-1:0] b;
    logic [W-1:0] ei, ev;
    int lat;
    for (int i = 0; i < SB; i++) b[i] = W'(SB - i);
    start_b_search(b);
    wait_done_b(60, lat);
    checks++; if (lat != LAT_B) begin errors++; $display("FAIL full_latency got %0d want %0d", lat, LAT_B); end
    for (int p = 0; p < PB; p++) begin
      checks++;
      if (int'(pidx_b[p]) != p || pval_b[p] !== W'(SB - p)) begin
        errors++; $display("FAIL full_peak%0d got idx %0d val %0d want idx %0d val %0d", p, pidx_b[p], pval_b[p], p, SB - p);
      end
    end
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < SB; i++) b[i] = W'($urandom_range(0, 3));
      model_push_b(b);
      start_b_search(b);
      wait_done_b(60, lat);
      checks++; if (lat != LAT_B) begin errors++; $display("FAIL full_rand%0d_latency got %0d want %0d", n, lat, LAT_B); end
      for (int p = 0; p < PB; p++) begin
        ei = exp_q.pop_front(); ev = exp_q.pop_front();
        checks++;
        if (pidx_b[p] !== ei[IWB-1:0] || pval_b[p] !== ev) begin
          errors++; $display("FAIL full_rand%0d_peak%0d got idx %0d val %0d want idx %0d val %0d", n, p, pidx_b[p], pval_b[p], ei, ev);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_all_equal();
    test_snapshot();
    test_abort();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    test_peaks_eq_samples();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_scan_controller.md
PEAK_SCAN_CONTROLLER -- requirements
Module: peak_scan_controller

Interface
REQ-001 The block SHALL have parameter SAMPLES, default 32: number of frequency bins (power of two, >= 4).
REQ-002 The block SHALL have parameter WIDTH, default 32: bin magnitude width in bits.
REQ-003 The block SHALL have parameter PEAKS, default 3: number of largest bins to report (1 <= PEAKS <= SAMPLES).
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-006 start  input  1  request a new peak search; accepted only in IDLE.
REQ-007 abort  input  1  terminate a search in progress; return to IDLE without done.
REQ-008 frequency_bins  input  SAMPLES x WIDTH  bin magnitudes; sampled only in the cycle start is accepted.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when all PEAKS results are valid.
REQ-011 peak_index  output  PEAKS x clog2(SAMPLES)  bin indices; entry 0 is the largest, descending.
REQ-012 peak_value  output  PEAKS x WIDTH  magnitude for the matching peak_index entry.
REQ-013 result_valid  output  1  high from done until the next accepted start, reset or abort.

Function
REQ-014 The FSM SHALL use states IDLE, SCAN, COMMIT, DONE.
REQ-015 IDLE: on start=1, SHALL copy frequency_bins into an internal snapshot, clear the exclusion mask, clear result_valid, zero the peak counter, and enter SCAN next cycle.
REQ-016 SCAN: SHALL examine exactly one bin per cycle, index 0 to SAMPLES-1, so SCAN lasts exactly SAMPLES cycles.
REQ-017 SCAN: bins with their mask bit set SHALL be skipped; the first unmasked bin SHALL load the candidate unconditionally.
REQ-018 SCAN: a later bin SHALL replace the candidate only if strictly greater (unsigned), so ties resolve to the lowest index.
REQ-019 COMMIT (1 cycle): SHALL write the candidate index and value to entry [peak counter], set that bin's mask bit, and increment the counter.
REQ-020 After COMMIT: SHALL go to SCAN if counter < PEAKS, otherwise to DONE.
REQ-021 DONE (1 cycle): SHALL assert done=1 and set result_valid=1, then go to IDLE.
REQ-022 Latency from the accepting clock edge to done=1 SHALL be exactly PEAKS*(SAMPLES+1)+1 cycles.
REQ-023 start while busy=1 SHALL be ignored; no queuing.
REQ-024 abort=1 in SCAN or COMMIT SHALL force IDLE on the next cycle, with result_valid=0 and no done pulse. Partially written entries SHALL be left undefined-for-use.
REQ-025 abort SHALL take priority over start; abort in IDLE or DONE SHALL have no effect, except that DONE still completes.
REQ-026 Changes on frequency_bins after acceptance SHALL NOT affect results.
REQ-027 All-equal bins SHALL yield indices 0,1,...,PEAKS-1.
REQ-028 The scan index counter SHALL be clog2(SAMPLES) bits wide and SHALL wrap to 0 on leaving SCAN. The peak counter SHALL be clog2(PEAKS+1) bits wide.

Reset
REQ-029 reset=0 SHALL force IDLE, busy=0, done=0, result_valid=0, all peak_index=0, all peak_value=0, mask=0, counters=0, taking priority over start and abort in any state, including mid-SCAN.

Structure
REQ-030 Package peak_scan_pkg SHALL hold the state enum (IDLE, SCAN, COMMIT, DONE) and an IDX_W = clog2(SAMPLES) helper function.
REQ-031 Sub-module bin_argmax_step SHALL hold the candidate register, masked compare and tie rule. The controller SHALL own the FSM, snapshot, mask and result registers.

Verification
REQ-032 SAMPLES=8, PEAKS=3, bins {5,90,12,90,3,40,7,1}, start -> done at cycle 28, indices {1,3,5}, values {90,90,40}.
REQ-033 All bins 7 -> indices {0,1,2}, values {7,7,7}.
REQ-034 Bins change 2 cycles after start, plus a second start mid-search -> results match the original snapshot; exactly one done pulse.
REQ-035 abort at cycle 10 -> busy=0 on cycle 11, no done, result_valid=0; a fresh start completes normally.
REQ-036 reset=0 mid-SCAN for one cycle -> all outputs zero next cycle; no done pulse.
REQ-037 PEAKS=SAMPLES=4, bins {4,3,2,1} -> indices {0,1,2,3}, done at cycle 21.
